// File: rtl/subpel_sad_ctrl_if.sv
// Handshake, window and result signals between the SAD sequencer and its neighbours.
// The master side drives the block data. The slave side is the sequencer.
interface subpel_sad_ctrl_if #(
   parameter int unsigned ACC_W = 14
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [63:0]       ref_pix;
   logic [47:0]       org_pix;
   logic [63:0]       win_upper;
   logic [63:0]       win_middle;
   logic [63:0]       win_lower;
   logic [47:0]       win_org;
   logic [1199:0]     diff_bus;
   logic              busy;
   logic              done;
   logic [4:0]        best_idx;
   logic [ACC_W-1:0]  best_sad;

   modport master (
      output start, in_valid, ref_pix, org_pix, diff_bus,
      input  in_ready, win_upper, win_middle, win_lower, win_org,
      input  busy, done, best_idx, best_sad
   );

   modport slave (
      input  start, in_valid, ref_pix, org_pix, diff_bus,
      output in_ready, win_upper, win_middle, win_lower, win_org,
      output busy, done, best_idx, best_sad
   );
endinterface

// File: rtl/subpel_sad_ctrl.sv
// Fractional-pel SAD sequencer: it slides a 3-row reference window, accumulates 25 SADs
// and picks the best position. The integer position (k = 12) wins ties.
module subpel_sad_ctrl #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned ACC_W = 14
) (
   input logic             clk,
   input logic             rst,
   subpel_sad_ctrl_if.slave bus
);
   localparam int unsigned NumPos = 25;
   localparam int unsigned SlotW  = 6 * PIX_W;

   typedef enum logic [2:0] {StIdle, StLoad, StDrain, StSearch, StDone} state_e;

   state_e            state_q, state_d;
   logic [2:0]        beat_q;
   logic [4:0]        scan_q;
   logic              win_ok_q;
   logic [63:0]       win_upper_q, win_middle_q, win_lower_q;
   logic [47:0]       win_org_q;
   logic [ACC_W-1:0]  acc_q [NumPos];
   logic [ACC_W-1:0]  row_sum [NumPos];
   logic [ACC_W-1:0]  best_sad_q, cur_sad, next_sad;
   logic [4:0]        best_idx_q, cur_idx, next_idx;
   logic              beat_acc;

   assign beat_acc = (state_q == StLoad) && bus.in_valid;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (bus.start) state_d = StLoad;
         StLoad:   if (beat_acc && beat_q == 3'd7) state_d = StDrain;
         StDrain:  state_d = StSearch;
         StSearch: if (scan_q == 5'd24) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NumPos; k++) begin
         row_sum[k] = '0;
         for (int i = 0; i < 6; i++) begin
            row_sum[k] = row_sum[k] + ACC_W'(bus.diff_bus[SlotW*k + PIX_W*i +: PIX_W]);
         end
      end
   end

   // The first scan step compares against acc[12] directly, which seeds the integer position.
   always_comb begin
      cur_sad  = (scan_q == 5'd0) ? acc_q[12] : best_sad_q;
      cur_idx  = (scan_q == 5'd0) ? 5'd12 : best_idx_q;
      next_sad = cur_sad;
      next_idx = cur_idx;
      if (scan_q != 5'd12 && acc_q[scan_q] < cur_sad) begin
         next_sad = acc_q[scan_q];
         next_idx = scan_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         scan_q       <= '0;
         win_ok_q     <= 1'b0;
         win_upper_q  <= '0;
         win_middle_q <= '0;
         win_lower_q  <= '0;
         win_org_q    <= '0;
         best_sad_q   <= '0;
         best_idx_q   <= '0;
         for (int k = 0; k < NumPos; k++) acc_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         win_ok_q <= beat_acc && (beat_q >= 3'd2);
         if (state_q == StIdle && bus.start) begin
            beat_q <= '0;
            for (int k = 0; k < NumPos; k++) acc_q[k] <= '0;
         end else if (win_ok_q) begin
            for (int k = 0; k < NumPos; k++) acc_q[k] <= acc_q[k] + row_sum[k];
         end
         if (beat_acc) begin
            win_upper_q  <= win_middle_q;
            win_middle_q <= win_lower_q;
            win_lower_q  <= bus.ref_pix;
            win_org_q    <= bus.org_pix;
            beat_q       <= beat_q + 3'd1;
         end
         if (state_q == StDrain) begin
            scan_q <= '0;
         end else if (state_q == StSearch) begin
            scan_q     <= scan_q + 5'd1;
            best_sad_q <= next_sad;
            best_idx_q <= next_idx;
         end
      end
   end

   assign bus.in_ready   = (state_q == StLoad);
   assign bus.busy       = (state_q != StIdle);
   assign bus.done       = (state_q == StDone);
   assign bus.win_upper  = win_upper_q;
   assign bus.win_middle = win_middle_q;
   assign bus.win_lower  = win_lower_q;
   assign bus.win_org    = win_org_q;
   assign bus.best_idx   = best_idx_q;
   assign bus.best_sad   = best_sad_q;
endmodule

// File: tb/tb_subpel_sad_ctrl.sv
// Self-checking bench for subpel_sad_ctrl. A behavioural model tracks the last three accepted
// rows and the per-position SAD sums, and picks the winner as the minimum with preference for 12.
module tb_subpel_sad_ctrl;
   localparam int unsigned ACC_W = 14;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   subpel_sad_ctrl_if #(.ACC_W(ACC_W)) bus ();

   subpel_sad_ctrl #(.PIX_W(8), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [63:0] hist [3];   // [0] = newest accepted row
   logic [47:0] org_hist;
   int unsigned pat [25];

   task automatic set_pat(input int a, input int b, input int va, input int vo);
      for (int k = 0; k < 25; k++) pat[k] = (k == a || k == b) ? va : vo;
   endtask

   // vmode: 0 valid every cycle, 1 valid on odd cycles, 2 random valid
   task automatic run_block(input int vmode, input bit rdiff, input bit rrows, input int abort_at,
                            input int start_at, output int obs_done, output logic [4:0] obs_idx,
                            output logic [ACC_W-1:0] obs_sad);
      int c, beats, exp_done, eidx;
      bit pend, acc_now;
      int unsigned macc [25];
      int unsigned m, bv;
      logic [63:0] row;
      logic [47:0] org;
      logic [1199:0] db;
      obs_done = -1;
      obs_idx  = '0;
      obs_sad  = '0;
      for (int k = 0; k < 25; k++) macc[k] = 0;
      beats = 0; pend = 0; exp_done = 1000; c = 0;
      bus.start = 1'b1; bus.in_valid = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      c = 1;
      while (c <= exp_done + 1 && c < 300) begin
         bus.in_valid = 1'b0;
         if (beats < 8) begin
            case (vmode)
               0:       bus.in_valid = 1'b1;
               1:       bus.in_valid = (c % 2 == 1);
               default: bus.in_valid = (c > 60) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
         end
         row = rrows ? {$urandom, $urandom} : {8{8'(beats + 1)}};
         org = rrows ? 48'({$urandom, $urandom}) : {6{8'(32'h10 + beats - 1)}};
         bus.ref_pix = row;
         bus.org_pix = org;
         bus.start   = (c == start_at);
         for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 6; i++) begin
               bv = rdiff ? $urandom_range(0, 255) : pat[k];
               db[48*k + 8*i +: 8] = 8'(bv);
               if (pend) macc[k] += bv;
            end
         end
         bus.diff_bus = db;
         if (c == abort_at) break;
         @(negedge clk);
         total++;
         if (bus.in_ready !== (beats < 8)) begin
            bad++; $display("FAIL in_ready c=%0d got=%b want=%b", c, bus.in_ready, beats < 8);
         end
         total++;
         if (bus.busy !== (c <= exp_done)) begin
            bad++; $display("FAIL busy c=%0d got=%b want=%b", c, bus.busy, c <= exp_done);
         end
         total++;
         if (bus.done !== (c == exp_done)) begin
            bad++; $display("FAIL done c=%0d got=%b want=%b", c, bus.done, c == exp_done);
         end
         total++;
         if ({bus.win_upper, bus.win_middle, bus.win_lower, bus.win_org} !==
             {hist[2], hist[1], hist[0], org_hist}) begin
            bad++;
            $display("FAIL window c=%0d got=%h/%h/%h/%h want=%h/%h/%h/%h", c, bus.win_upper,
                     bus.win_middle, bus.win_lower, bus.win_org, hist[2], hist[1], hist[0],
                     org_hist);
         end
         if (bus.done === 1'b1 && obs_done < 0) begin
            obs_done = c; obs_idx = bus.best_idx; obs_sad = bus.best_sad;
         end
         if (c >= exp_done) begin
            m = macc[0];
            for (int k = 1; k < 25; k++) if (macc[k] < m) m = macc[k];
            eidx = -1;
            if (macc[12] == m) eidx = 12;
            for (int k = 0; k < 25; k++) if (eidx < 0 && macc[k] == m) eidx = k;
            total++;
            if (bus.best_idx !== 5'(eidx) || bus.best_sad !== ACC_W'(m)) begin
               bad++;
               $display("FAIL best c=%0d got idx=%0d sad=%0d want idx=%0d sad=%0d", c,
                        bus.best_idx, bus.best_sad, eidx, m);
            end
         end
         @(posedge clk); #1;
         acc_now = bus.in_valid && (beats < 8);
         pend    = acc_now && (beats >= 2);
         if (acc_now) begin
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = row; org_hist = org;
            beats++;
            if (beats == 8) exp_done = c + 27;
         end
         c++;
      end
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      if (abort_at == 0) begin
         total++;
         if (obs_done < 0) begin
            bad++; $display("FAIL no_done got=none want=pulse by cycle %0d", exp_done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.in_valid = 1'b0;
      bus.ref_pix = '0; bus.org_pix = '0; bus.diff_bus = '0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0; org_hist = '0;
      #12;
      total++;
      if ({bus.in_ready, bus.busy, bus.done, bus.best_idx, bus.best_sad} !== '0 ||
          {bus.win_upper, bus.win_middle, bus.win_lower, bus.win_org} !== '0) begin
         bad++;
         $display("FAIL reset_state got rdy=%b busy=%b done=%b idx=%0d sad=%0d want all zero",
                  bus.in_ready, bus.busy, bus.done, bus.best_idx, bus.best_sad);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_window();
      int d; logic [4:0] idx; logic [ACC_W-1:0] sad;
      set_pat(0, 0, 1, 1);
      run_block(0, 1'b0, 1'b0, 0, 0, d, idx, sad);
      total++;
      if (bus.win_upper !== 64'h0606060606060606 || bus.win_middle !== 64'h0707070707070707 ||
          bus.win_lower !== 64'h0808080808080808 || bus.win_org !== 48'h161616161616) begin
         bad++;
         $display("FAIL window_final got=%h/%h/%h/%h want=06../07../08../16..", bus.win_upper,
                  bus.win_middle, bus.win_lower, bus.win_org);
      end
   endtask

   task automatic test_unique_min();
      int d; logic [4:0] idx; logic [ACC_W-1:0] sad;
      set_pat(3, 3, 2, 10);
      run_block(0, 1'b0, 1'b1, 0, 0, d, idx, sad);
      total++;
      if (d !== 35 || idx !== 5'd3 || sad !== ACC_W'(72)) begin
         bad++; $display("FAIL unique_min got cyc=%0d idx=%0d sad=%0d want 35/3/72", d, idx, sad);
      end
   endtask

   task automatic test_tie();
      int d; logic [4:0] idx; logic [ACC_W-1:0] sad;
      set_pat(3, 12, 1, 5);
      run_block(0, 1'b0, 1'b1, 0, 0, d, idx, sad);
      total++;
      if (idx !== 5'd12 || sad !== ACC_W'(36)) begin
         bad++; $display("FAIL tie_int got idx=%0d sad=%0d want 12/36", idx, sad);
      end
      set_pat(3, 20, 1, 5);
      run_block(0, 1'b0, 1'b1, 0, 0, d, idx, sad);
      total++;
      if (idx !== 5'd3 || sad !== ACC_W'(36)) begin
         bad++; $display("FAIL tie_low got idx=%0d sad=%0d want 3/36", idx, sad);
      end
   endtask

   task automatic test_stall();
      int d; logic [4:0] idx; logic [ACC_W-1:0] sad;
      set_pat(3, 3, 2, 10);
      run_block(1, 1'b0, 1'b1, 0, 0, d, idx, sad);
      total++;
      if (d !== 42 || idx !== 5'd3 || sad !== ACC_W'(72)) begin
         bad++; $display("FAIL stall got cyc=%0d idx=%0d sad=%0d want 42/3/72", d, idx, sad);
      end
   endtask

   task automatic test_saturation();
      int d; logic [4:0] idx; logic [ACC_W-1:0] sad;
      set_pat(0, 0, 255, 255);
      run_block(0, 1'b0, 1'b1, 0, 0, d, idx, sad);
      total++;
      if (idx !== 5'd12 || sad !== ACC_W'(9180)) begin
         bad++; $display("FAIL saturation got idx=%0d sad=%0d want 12/9180", idx, sad);
      end
   endtask

   task automatic test_random();
      int d; logic [4:0] idx; logic [ACC_W-1:0] sad;
      for (int n = 0; n < 4; n++) run_block(2, 1'b1, 1'b1, 0, 0, d, idx, sad);
   endtask

   task automatic test_reset_mid_search();
      int d; logic [4:0] idx; logic [ACC_W-1:0] sad;
      set_pat(3, 3, 2, 10);
      run_block(0, 1'b0, 1'b1, 20, 0, d, idx, sad);
      rst = 1'b1;
      hist[0] = '0; hist[1] = '0; hist[2] = '0; org_hist = '0;
      #1;
      total++;
      if ({bus.in_ready, bus.busy, bus.done, bus.best_idx, bus.best_sad} !== '0 ||
          {bus.win_upper, bus.win_middle, bus.win_lower, bus.win_org} !== '0) begin
         bad++;
         $display("FAIL reset_mid got rdy=%b busy=%b done=%b idx=%0d sad=%0d want all zero",
                  bus.in_ready, bus.busy, bus.done, bus.best_idx, bus.best_sad);
      end
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         total++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abandoned n=%0d got done=%b busy=%b want 0/0", n, bus.done,
                            bus.busy);
         end
      end
      @(posedge clk); #1;
      run_block(0, 1'b0, 1'b1, 0, 4, d, idx, sad);
      total++;
      if (d !== 35 || idx !== 5'd3 || sad !== ACC_W'(72)) begin
         bad++; $display("FAIL after_reset got cyc=%0d idx=%0d sad=%0d want 35/3/72", d, idx, sad);
      end
   endtask

   initial begin
      test_reset();
      test_window();
      test_unique_min();
      test_tie();
      test_stall();
      test_saturation();
      test_random();
      test_reset_mid_search();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/subpel_sad_ctrl.md
Name: subpel_sad_ctrl

Overview:
Sequencer and result selector for the fractional-pel SAD line datapath (abs_diff_line).
- Accepts the 8 reference rows of an 8x8 block and the 6 original rows of the inner 6x6 block.
- Drives a sliding 3-row window (upper, middle, lower) plus the matching original row into the datapath.
- Accumulates the 25 per-line absolute-difference vectors into 25 SADs over 6 lines.
- Scans the SADs and reports the best fractional position and its SAD.

Parameters:
PIX_W, 8, pixel width; only 8 supported.
ACC_W, 14, SAD accumulator width; must be >= 14 (36*255 = 9180).

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  begin a block; sampled only in IDLE
in_valid  input  1  ref_pix/org_pix beat valid
in_ready  output  1  beat accepted when in_valid & in_ready
ref_pix  input  64  one reference row, 8 pixels
org_pix  input  48  inner 6 original pixels of the row matching the window middle
win_upper  output  64  datapath upper row
win_middle  output  64  datapath middle row
win_lower  output  64  datapath lower row
win_org  output  48  datapath original row
diff_bus  input  1200  25 datapath diff vectors of 48 bits each; slot k at [48k+47:48k]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the result is valid
best_idx  output  5  winning position 0..24
best_sad  output  ACC_W  SAD of the winning position

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset: FSM goes to IDLE. All window registers, accumulators, counters, best_idx, best_sad, done, busy and in_ready clear to 0. Reset mid-operation abandons the block; no done is produced.
- Position index k = row*5 + col.
  - row order: UH, UQ, M, LQ, LH.
  - col order: h, q, f, r, i.
  - k = 12 is the integer position (M_f).
- IDLE:
  - in_ready = 0.
  - start = 1 clears all 25 accumulators and the beat counter, then goes to LOAD.
  - start in any other state is ignored.
- LOAD:
  - in_ready = 1. Beat counter b runs 0..7.
  - On an accepted beat: win_upper <= win_middle; win_middle <= win_lower; win_lower <= ref_pix; win_org <= org_pix; b++.
  - org_pix is don't-care on beats 0 and 1. On beat b >= 2 it is original row b-1.
  - win_ok is a registered flag, set for exactly one cycle after each accepted beat with b >= 2. While win_ok = 1, acc[k] += sum of the 6 bytes of diff slot k, zero-extended.
  - When in_valid = 0, the window holds and win_ok = 0.
  - After beat 7 is accepted, go to DRAIN.
- DRAIN (1 cycle): in_ready = 0. Performs the final accumulation (win_ok = 1), then goes to SEARCH.
- SEARCH (25 cycles):
  - On entry, best = acc[12] and best_idx = 12.
  - Scan k = 0..24, skipping 12 (held idle).
  - Replace best only when acc[k] < best (strict). Ties therefore keep the integer position, otherwise the lowest k.
- DONE (1 cycle): done = 1, then go to IDLE.
- Result hold: best_idx and best_sad hold their values until the next start and are valid from the done cycle onward.
- Latency: with in_valid held high and start sampled in cycle 0:
  - beats accepted in cycles 1..8;
  - DRAIN in cycle 9;
  - SEARCH in cycles 10..34;
  - done in cycle 35.
  - Each stall cycle adds 1 cycle.
- Width: a row sum is 11 bits; the accumulator does not wrap for legal inputs.

Test Plan:
1. Window sequencing: rows r0..r7 with every byte = i+1; org row j bytes = 0x10+j -> after beat 2: win_upper = 0x0101..01, win_middle = 0x02.., win_lower = 0x03.., win_org = 0x11..; after beat 7: 0x06/0x07/0x08.., win_org = 0x16..
2. Unique minimum: bench model drives all diff bytes = 10 except slot 3 = 2 -> acc[3] = 72, others 360; best_idx = 3, best_sad = 72, done at cycle 35.
3. Tie-break: slots 3 and 12 bytes = 1, others 5 -> best_idx = 12, best_sad = 36. Slots 3 and 20 bytes = 1, others 5 -> best_idx = 3.
4. Stall: in_valid high only on odd cycles 1,3,..,15 -> same result as test 2, done in cycle 42, busy high cycles 1..42.
5. Saturation: all diff bytes 0xFF -> every acc = 9180; best_idx = 12, best_sad = 9180.
6. Reset mid-SEARCH (cycle 20): outputs 0, in_ready 0, no done; a following start repeating test 2 gives best_idx = 3, best_sad = 72. Also, start pulsed during LOAD is ignored.
